// File: rtl/fsm_2bit_if.sv
// fsm_2bit_if: update-path and register-path signals of the 2-bit saturating counter
interface fsm_2bit_if;
   logic       x;
   logic [1:0] state_old;
   logic [1:0] state;
   logic       en;
   logic [1:0] state_q;
   logic       pred;
   modport master (output x, state_old, en, input state, state_q, pred);
   modport slave (input x, state_old, en, output state, state_q, pred);
endinterface

// File: rtl/fsm_2bit.sv
// fsm_2bit: 2-bit saturating branch counter with combinational update and one registered copy
module fsm_2bit (
   input logic        clk,
   input logic        rst,
   fsm_2bit_if.slave  bus
);
   typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;
   ctr_t cur = SNT;
   ctr_t nxt;
   function automatic ctr_t step(input ctr_t s, input logic t);
      step = t ? ((s == ST) ? ST : ctr_t'(s + 2'd1)) : ((s == SNT) ? SNT : ctr_t'(s - 2'd1));
   endfunction
   // counter register; reset wins over the load enable
   always_ff @(posedge clk) begin
      if (rst) cur <= SNT;
      else cur <= nxt;
   end
   // register next value: advance only when enabled
   always_comb begin
      nxt = cur;
      if (bus.en) nxt = step(cur, bus.x);
   end
   // caller-facing update works on the supplied table entry, never on the register
   always_comb begin
      bus.state = 2'b00;
      if (!rst) bus.state = step(ctr_t'(bus.state_old), bus.x);
   end
   assign bus.state_q = cur;
   assign bus.pred    = cur[1];
endmodule

// File: tb/tb_fsm_2bit.sv
// tb_fsm_2bit: directed scoreboard bench for the 2-bit saturating counter
module tb_fsm_2bit;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int n_pass = 0;
   int n_total = 0;
   typedef struct {string tag; logic [2:0] val;} exp_t;
   exp_t sb[$];
   logic [1:0] up[4] = '{2'd1, 2'd2, 2'd3, 2'd3};
   logic [1:0] dn[4] = '{2'd0, 2'd0, 2'd1, 2'd2};
   logic [1:0] sat[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
   logic [1:0] dec[4] = '{2'd2, 2'd1, 2'd0, 2'd0};
   fsm_2bit_if bus ();
   fsm_2bit dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic push_exp(input string tag, input logic [2:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask
   task automatic check(input logic [2:0] obs);
      exp_t e;
      e = sb.pop_front();
      n_total++;
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s: got %b expected %b", e.tag, obs, e.val);
   endtask
   task automatic comb(input string tag, input logic r, input logic [1:0] so, input logic xi, input logic [1:0] ex);
      @(negedge clk);
      rst = r;
      bus.state_old = so;
      bus.x = xi;
      push_exp(tag, {1'b0, ex});
      #1;
      check({1'b0, bus.state});
   endtask
   task automatic tick(input string tag, input logic r, input logic e, input logic xi, input logic [1:0] ex);
      rst = r;
      bus.en = e;
      bus.x = xi;
      push_exp(tag, {ex[1], ex});
      @(posedge clk);
      #1;
      check({bus.pred, bus.state_q});
   endtask
   initial begin
      bus.x = 1'b0;
      bus.en = 1'b0;
      bus.state_old = 2'b00;
      #1;
      push_exp("power_up", 3'b000);
      check({bus.pred, bus.state_q});
      tick("reset", 1'b1, 1'b0, 1'b0, 2'd0);
      for (int i = 0; i < 4; i++) comb($sformatf("up_%0d", i), 1'b0, 2'(i), 1'b1, up[i]);
      for (int i = 0; i < 4; i++) comb($sformatf("dn_%0d", i), 1'b0, 2'(i), 1'b0, dn[i]);
      comb("comb_rst", 1'b1, 2'd3, 1'b1, 2'd0);
      comb("comb_rel", 1'b0, 2'd3, 1'b1, 2'd3);
      tick("reset2", 1'b1, 1'b0, 1'b0, 2'd0);
      for (int i = 0; i < 5; i++) tick($sformatf("sat_%0d", i), 1'b0, 1'b1, 1'b1, sat[i]);
      for (int i = 0; i < 4; i++) tick($sformatf("dec_%0d", i), 1'b0, 1'b1, 1'b0, dec[i]);
      tick("climb_0", 1'b0, 1'b1, 1'b1, 2'd1);
      tick("climb_1", 1'b0, 1'b1, 1'b1, 2'd2);
      for (int i = 0; i < 3; i++) tick($sformatf("hold_%0d", i), 1'b0, 1'b0, (i % 2) == 0, 2'd2);
      tick("to_st", 1'b0, 1'b1, 1'b1, 2'd3);
      comb("indep", 1'b0, 2'd0, 1'b0, 2'd0);
      tick("rst_prio", 1'b1, 1'b1, 1'b1, 2'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/fsm_2bit.md
# fsm_2bit

2-bit saturating-counter state machine for the branch predictor. Given a counter value and the resolved branch outcome, it produces the updated counter value combinationally. The pattern-history logic uses that result to write its per-pattern counter table. The block also holds one registered copy of the counter, for stand-alone use or per-entry instantiation, with a synchronous reset.

## Interface
Parameters:
- none (counter width fixed at 2 bits)

Ports:
- `clk`  input  1  rising-edge clock; drives only the internal counter register
- `rst`  input  1  reset, synchronous and active-high; clears the register; also forces `state` to 2'b00 while high
- `x`  input  1  resolved branch outcome (1 = taken, 0 = not taken)
- `state_old`  input  2  current counter value to be updated (table entry supplied by the caller)
- `state`  output  2  next counter value; combinational
- `en`  input  1  register load enable; tie high when unused
- `state_q`  output  2  registered counter value
- `pred`  output  1  prediction from the register, equal to `state_q[1]`

## Operation
- Encoding:
  - 00 = strongly not-taken
  - 01 = weakly not-taken
  - 10 = weakly taken
  - 11 = strongly taken
- The prediction is always bit 1 of a counter value.
- Next-state function for `state`, evaluated on `state_old` and `x` (rst = 0):
  - x=1: 00→01, 01→10, 10→11, 11→11 (saturates at 11)
  - x=0: 00→00 (saturates at 00), 01→00, 10→01, 11→10
- `rst`=1: `state` = 00 regardless of `x` or `state_old`.
- No wrap-around: 11 with x=1 stays 11; 00 with x=0 stays 00.
- `state` depends only on `rst`, `x` and `state_old`; it never depends on `state_q`.
- Register update on each rising `clk`:
  - rst=1: `state_q` ← 00. Reset has priority over `en`.
  - rst=0, en=1: `state_q` ← next-state function applied to the current `state_q` with `x`.
  - rst=0, en=0: `state_q` holds.
- `pred` = `state_q[1]`.
- Caller contract: the caller reads `state` combinationally and writes it back to its own storage on its clock edge, with `rst` tied to 0. Because `state` is purely combinational, the block adds no latency to that write-back.
- X-handling: any unknown bit on `x` or `state_old` may propagate to `state`. No X-masking is required.

## Timing
- `state`: zero-cycle combinational path from `x`, `state_old` and `rst`.
- `state_q`: one-cycle latency. A value applied before edge N is visible after edge N.
- Reset values: `state_q` = 00 and `pred` = 0 from the first edge with rst=1.
- Power-up value of `state_q` before the first reset is 00. An initial value is required for the simulation model, matching the caller's zero-initialised table.
- Reset asserted mid-sequence: the counter returns to 00 on that edge; any pending increment is discarded.
- rst and en both high on the same edge: the result is 00.

## Test plan
- Exhaustive combinational check, rst=0: all 8 combinations of `state_old` and `x`.
  - x=1: 00→01, 01→10, 10→11, 11→11
  - x=0: 00→00, 01→00, 10→01, 11→10
- Combinational reset: rst=1 with `state_old`=11, x=1 → `state`=00. Release rst → `state`=11.
- Register saturation: reset, then 5 edges with en=1, x=1.
  - `state_q` sequence 01, 10, 11, 11, 11
  - `pred` rises after the 2nd edge
- Register decay: continue from 11 with 4 edges, en=1, x=0.
  - `state_q` sequence 10, 01, 00, 00
  - `pred` falls after the 2nd edge
- Enable hold: `state_q`=10, en=0, toggle `x` for 3 edges → `state_q` stays 10.
- Reset priority: `state_q`=11, en=1, x=1, rst=1 on one edge → `state_q`=00 and `pred`=0 after that edge.
